// File: rtl/dca_matrix_seq_ctrl_if.sv
// Bundles the command, row streams and matrix-register strobes of the DCA matrix sequencer.
// DCA_MATRIX_SEQ_PERF_EN adds the stall_cnt performance counter to the bundle.
interface dca_matrix_seq_ctrl_if #(
  parameter int unsigned MATRIX_SIZE      = 8,
  parameter int unsigned BW_TENSOR_SCALAR = 32
);
  localparam int unsigned BW_TENSOR_ROW = MATRIX_SIZE * BW_TENSOR_SCALAR;

  logic                     clear;
  logic                     cmd_valid;
  logic                     cmd_ready;
  logic                     cmd_transpose;
  logic                     in_valid;
  logic                     in_ready;
  logic [BW_TENSOR_ROW-1:0] in_data;
  logic                     out_valid;
  logic                     out_ready;
  logic [BW_TENSOR_ROW-1:0] out_data;
  logic                     done;
  logic                     busy;
  logic                     reg_move_wenable;
  logic [BW_TENSOR_ROW-1:0] reg_move_wdata_list;
  logic                     reg_move_renable;
  logic                     reg_shift_up;
  logic                     reg_shift_left;
  logic                     reg_transpose;
  logic [BW_TENSOR_ROW-1:0] reg_upmost_rdata;
`ifdef DCA_MATRIX_SEQ_PERF_EN
  logic [31:0]              stall_cnt;
`endif

`ifdef DCA_MATRIX_SEQ_PERF_EN
  modport slave (
    input  clear, cmd_valid, cmd_transpose, in_valid, in_data, out_ready, reg_upmost_rdata,
    output cmd_ready, in_ready, out_valid, out_data, done, busy, reg_move_wenable,
           reg_move_wdata_list, reg_move_renable, reg_shift_up, reg_shift_left, reg_transpose,
           stall_cnt
  );
  modport master (
    output clear, cmd_valid, cmd_transpose, in_valid, in_data, out_ready, reg_upmost_rdata,
    input  cmd_ready, in_ready, out_valid, out_data, done, busy, reg_move_wenable,
           reg_move_wdata_list, reg_move_renable, reg_shift_up, reg_shift_left, reg_transpose,
           stall_cnt
  );
`else
  modport slave (
    input  clear, cmd_valid, cmd_transpose, in_valid, in_data, out_ready, reg_upmost_rdata,
    output cmd_ready, in_ready, out_valid, out_data, done, busy, reg_move_wenable,
           reg_move_wdata_list, reg_move_renable, reg_shift_up, reg_shift_left, reg_transpose
  );
  modport master (
    output clear, cmd_valid, cmd_transpose, in_valid, in_data, out_ready, reg_upmost_rdata,
    input  cmd_ready, in_ready, out_valid, out_data, done, busy, reg_move_wenable,
           reg_move_wdata_list, reg_move_renable, reg_shift_up, reg_shift_left, reg_transpose
  );
`endif
endinterface

// File: rtl/dca_matrix_seq_ctrl.sv
// Load / optional transpose / drain sequencer that is sole master of a DCA matrix register.
// Defining DCA_MATRIX_SEQ_PERF_EN adds a saturating stall counter (bus.stall_cnt).
module dca_matrix_seq_ctrl #(
  parameter int unsigned MATRIX_SIZE      = 8,
  parameter int unsigned BW_TENSOR_SCALAR = 32
) (
  input  logic                 clk,
  input  logic                 rstnn,
  dca_matrix_seq_ctrl_if.slave bus
);
  localparam int unsigned BW_TENSOR_ROW = MATRIX_SIZE * BW_TENSOR_SCALAR;
  localparam int unsigned CntW = (MATRIX_SIZE > 1) ? $clog2(MATRIX_SIZE) : 1;
  localparam logic [CntW-1:0] LastRow = CntW'(MATRIX_SIZE - 1);

  typedef enum logic [2:0] {
    StIdle, StLoad, StXpose, StSettle, StDrain, StDone
  } state_e;

  state_e          state_q, state_d;
  logic [CntW-1:0] row_cnt_q, row_cnt_d;
  logic            xpose_q, xpose_d;

  logic cmd_ready, cmd_fire, in_ready, out_valid;
  logic move_wen, shift_up, xpose, done;

  always_comb begin
    state_d   = state_q;
    row_cnt_d = row_cnt_q;
    xpose_d   = xpose_q;
    cmd_ready = 1'b0;
    cmd_fire  = 1'b0;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    move_wen  = 1'b0;
    shift_up  = 1'b0;
    xpose     = 1'b0;
    done      = 1'b0;

    // Ready/valid and strobes are masked by clear so an aborted cycle moves nothing.
    unique case (state_q)
      StIdle: begin
        cmd_ready = ~bus.clear;
        if (bus.cmd_valid && cmd_ready) begin
          cmd_fire  = 1'b1;
          xpose_d   = bus.cmd_transpose;
          row_cnt_d = '0;
          state_d   = StLoad;
        end
      end
      StLoad: begin
        in_ready = ~bus.clear;
        move_wen = bus.in_valid & in_ready;
        if (move_wen) begin
          if (row_cnt_q == LastRow) begin
            row_cnt_d = '0;
            state_d   = xpose_q ? StXpose : StDrain;
          end else begin
            row_cnt_d = row_cnt_q + 1'b1;
          end
        end
      end
      StXpose: begin
        xpose   = ~bus.clear;
        state_d = StSettle;
      end
      StSettle: begin
        state_d = StDrain;
      end
      StDrain: begin
        out_valid = ~bus.clear;
        shift_up  = out_valid & bus.out_ready;
        if (shift_up) begin
          if (row_cnt_q == LastRow) begin
            row_cnt_d = '0;
            state_d   = StDone;
          end else begin
            row_cnt_d = row_cnt_q + 1'b1;
          end
        end
      end
      StDone: begin
        done    = 1'b1;
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase

    if (bus.clear) begin
      state_d   = StIdle;
      row_cnt_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rstnn) begin
    if (!rstnn) begin
      state_q   <= StIdle;
      row_cnt_q <= '0;
      xpose_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      row_cnt_q <= row_cnt_d;
      xpose_q   <= xpose_d;
    end
  end

  assign bus.cmd_ready           = cmd_ready;
  assign bus.in_ready            = in_ready;
  assign bus.out_valid           = out_valid;
  assign bus.out_data            = (state_q == StDrain) ? bus.reg_upmost_rdata
                                                        : {BW_TENSOR_ROW{1'b0}};
  assign bus.done                = done;
  assign bus.busy                = (state_q != StIdle);
  assign bus.reg_move_wenable    = move_wen;
  assign bus.reg_move_wdata_list = (state_q == StLoad) ? bus.in_data : {BW_TENSOR_ROW{1'b0}};
  assign bus.reg_move_renable    = 1'b0;
  assign bus.reg_shift_up        = shift_up;
  assign bus.reg_shift_left      = 1'b0;
  assign bus.reg_transpose       = xpose;

`ifdef DCA_MATRIX_SEQ_PERF_EN
  logic [31:0] stall_cnt_q;
  logic        stall;

  assign stall = ((state_q == StLoad) & ~bus.in_valid) | (out_valid & ~bus.out_ready);

  always_ff @(posedge clk or negedge rstnn) begin
    if (!rstnn) begin
      stall_cnt_q <= '0;
    end else if (cmd_fire) begin
      stall_cnt_q <= '0;
    end else if (stall && (stall_cnt_q != 32'hFFFF_FFFF)) begin
      stall_cnt_q <= stall_cnt_q + 32'd1;
    end
  end

  assign bus.stall_cnt = stall_cnt_q;
`endif

endmodule
